// File: rtl/prog_counter_if.sv
// Control/status bundle for prog_counter; the master drives the controls,
// the counter (slave) returns the count and strobes.
interface prog_counter_if #(
    parameter int WIDTH = 8
);
    logic             en_p;
    logic             en_t;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] term;
    logic             up;
    logic             one_shot;
    logic [WIDTH-1:0] q;
    logic             rco;
    logic             tick;
    logic             done;

    modport master (
        output en_p, en_t, load, d, term, up, one_shot,
        input  q, rco, tick, done
    );

    modport slave (
        input  en_p, en_t, load, d, term, up, one_shot,
        output q, rco, tick, done
    );
endinterface

// File: rtl/prog_counter.sv
// Prescaled up/down counter with programmable terminal count, parallel load,
// periodic or one-shot mode, and a cascadable ripple-carry output.
module prog_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 10000
) (
    input  logic          clk,
    input  logic          clr,
    prog_counter_if.slave bus
);
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_cnt;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_adv;
    logic             done_r;
    logic             en;
    logic             eoc;
    logic             tick_w;

    assign en     = bus.en_p & bus.en_t;
    assign eoc    = bus.up ? (q_r == bus.term) : (q_r == '0);
    assign tick_w = en & (pre_cnt == PRE_LAST);

    // Plain +/-1 step; the end-of-count wrap/reload is chosen in the register block.
    always_comb begin
        q_adv = q_r;
        if (bus.up) q_adv = q_r + WIDTH'(1);
        else        q_adv = q_r - WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_r     <= '0;
            pre_cnt <= '0;
            done_r  <= 1'b0;
        end else if (bus.load) begin
            q_r     <= bus.d;
            pre_cnt <= '0;
            done_r  <= 1'b0;
        end else if (en) begin
            pre_cnt <= tick_w ? '0 : pre_cnt + PW'(1);
            if (tick_w) begin
                if (bus.one_shot) begin
                    // Once done is set, q is frozen until load/clr or a switch to periodic.
                    if (!done_r) begin
                        if (eoc) done_r <= 1'b1;
                        else     q_r    <= q_adv;
                    end
                end else begin
                    done_r <= 1'b0;
                    if (eoc) q_r <= bus.up ? '0 : bus.term;
                    else     q_r <= q_adv;
                end
            end
        end
    end

    assign bus.q    = q_r;
    assign bus.done = done_r;
    assign bus.tick = tick_w;
    assign bus.rco  = bus.en_t & eoc;
endmodule
